lp_arith_seq: RTL and testbench

Sequential, handshaked responder for the low-power arithmetic datapath. Accepts one operand pair plus opcode per transaction on a valid/ready request channel. Computes add, subtract or unsigned multiply; multiply uses an iterative shift-add engine rather than a full array multiplier. Returns a double-width result on a valid/ready response channel. Operand and datapath registers toggle only while a transaction is in flight, so the block sits between a request initiator (sequencer or bench) and downstream result consumers, replacing the purely combinational unit where area and switching power matter more than latency.

---
 rtl/lp_arith_pkg.sv | 23 ++
 rtl/lp_shift_add_mul.sv | 55 +++++
 rtl/lp_arith_seq.sv | 106 ++++++++++
 tb/tb_lp_arith_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lp_arith_pkg.sv
// Shared types and helpers for the low-power arithmetic datapath
// (sequential responder, combinational unit and their benches).
package lp_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_INV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Result width for a given operand width: products never truncate.
    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/lp_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per enabled cycle,
// LSB first. Registers only move on start or while enabled.
module lp_shift_add_mul
    import lp_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      en,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      done,
    output logic [res_w(WIDTH)-1:0]   product
);

    localparam int RW = res_w(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    acc_nxt;
    logic [CW-1:0]    cnt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign done    = en && (cnt == CW'(WIDTH - 1));
    // The final partial sum is handed out combinationally so the caller can
    // register it on the last iteration edge without an extra cycle.
    assign product = acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (en) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/lp_arith_seq.sv
// Handshaked add/sub/multiply responder; multiply runs on the shift-add engine,
// everything else completes in one cycle.
module lp_arith_seq
    import lp_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [WIDTH-1:0]          req_a,
    input  logic [WIDTH-1:0]          req_b,
    input  logic [1:0]                req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [res_w(WIDTH)-1:0]   rsp_result,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int RW = res_w(WIDTH);

    state_e        state, state_n;
    op_e           op;
    logic          accept, start, mul_en, mul_done, zero_op;
    logic [RW-1:0] a_ext, b_ext, product, res_q;
    logic          err_q;

    assign op      = op_e'(req_op);
    assign zero_op = (req_a == '0) || (req_b == '0);
    assign a_ext   = {{WIDTH{1'b0}}, req_a};
    assign b_ext   = {{WIDTH{1'b0}}, req_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        start     = 1'b0;
        mul_en    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (op == OP_MUL && !zero_op) begin
                        start   = 1'b1;
                        state_n = MUL;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            MUL: begin
                mul_en = 1'b1;
                if (mul_done) state_n = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Response register doubles as the operand capture for single-cycle ops;
    // it only loads on accept or on the last multiply iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            case (op)
                OP_ADD:  res_q <= a_ext + b_ext;
                OP_SUB:  res_q <= a_ext - b_ext;
                default: res_q <= '0;
            endcase
            err_q <= (op == OP_INV);
        end else if (mul_en && mul_done) begin
            res_q <= product;
        end
    end

    assign rsp_result = res_q;
    assign rsp_err    = err_q;

    lp_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .en      (mul_en),
        .a       (req_a),
        .b       (req_b),
        .done    (mul_done),
        .product (product)
    );

endmodule

// File: tb/tb_lp_arith_seq.sv
// Scoreboard bench for lp_arith_seq: expected responses queued on accept,
// compared (value, latency, stability, flow control) as the DUT responds.
module tb_lp_arith_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t em;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   last_acc = 0;
    int   a1, hs;
    bit   inflight = 1'b0;

    lp_arith_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        logic [15:0] ax, bx;
        ax = {8'h00, a};
        bx = {8'h00, b};
        case (op)
            2'b00:   return ax + bx;
            2'b01:   return ax - bx;
            2'b10:   return ax * bx;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [15:0] res, input logic err, input int lat);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            e.res = res; e.err = err; e.lat = lat; e.acc = cyc;
            last_acc = cyc;
            sbq.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            inflight = 1'b0;
        end else begin
            if (sbq.size() > 0 && cyc > sbq[0].acc) chk("req_ready_busy", req_ready, 0);
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_rsp", rsp_valid, 0);
                end else begin
                    em = sbq[0];
                    if (!inflight) begin
                        chk("latency", cyc - em.acc, em.lat);
                        inflight = 1'b1;
                    end
                    chk("result", rsp_result, em.res);
                    chk("err", rsp_err, em.err);
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        inflight = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ops and arithmetic boundaries
        send(8'h0A, 8'h05, 2'b00, 16'h000F, 1'b0, 1);
        a1 = last_acc;
        send(8'h14, 8'h08, 2'b01, 16'h000C, 1'b0, 1);
        chk("thru_single", last_acc - a1, 2);
        send(8'hFF, 8'h01, 2'b00, 16'h0100, 1'b0, 1);
        send(8'h01, 8'hFF, 2'b01, 16'hFF02, 1'b0, 1);
        send(8'hFF, 8'hFF, 2'b01, 16'h0000, 1'b0, 1);
        send(8'h7F, 8'h01, 2'b00, 16'h0080, 1'b0, 1);

        // Multiply
        send(8'h03, 8'h02, 2'b10, 16'h0006, 1'b0, 9);
        a1 = last_acc;
        send(8'h80, 8'h80, 2'b10, 16'h4000, 1'b0, 9);
        chk("thru_mul", last_acc - a1, 10);
        send(8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0, 9);
        send(8'h55, 8'hAA, 2'b10, 16'h3872, 1'b0, 9);

        // Zero-skip and invalid opcode
        send(8'h00, 8'hFF, 2'b10, 16'h0000, 1'b0, 1);
        send(8'h01, 8'h01, 2'b11, 16'h0000, 1'b1, 1);
        drain();

        // Backpressure: result held, competing request waits for handshake
        @(posedge clk); #2 rsp_ready = 1'b0;
        send(8'hFF, 8'h02, 2'b10, 16'h01FE, 1'b0, 9);
        hs = 0;
        fork
            send(8'h0A, 8'h05, 2'b00, 16'h000F, 1'b0, 1);
            begin
                int guard = 0;
                while (!rsp_valid && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                if (!rsp_valid) chk("bp_rsp_timeout", 32'd0, 32'd1);
                repeat (5) @(negedge clk);
                @(posedge clk); #2 rsp_ready = 1'b1;
                hs = cyc;
            end
        join
        chk("bp_accept", last_acc, hs + 1);
        drain();

        // Reset during multiply iteration 4
        send(8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0, 9);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        #1;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("no_stale_valid", rsp_valid, 0);
        end
        send(8'h03, 8'h02, 2'b10, 16'h0006, 1'b0, 9);
        drain();

        // Random mix against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            logic [7:0] ra, rb;
            logic [1:0] rop;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 2'($urandom_range(0, 3));
            if (i % 4 == 0) rb = 8'h00;
            send(ra, rb, rop, model(ra, rb, rop), rop == 2'b11,
                 (rop == 2'b10 && ra != 0 && rb != 0) ? 9 : 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
